// File: rtl/banked_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : banked_mem_responder_pkg
//  Brief    : Shared constants for the four-bank interleaved memory responder.
//  Revision : 1.0  initial release
// ============================================================================
package banked_mem_responder_pkg;

    localparam int NUM_BANKS   = 4;
    localparam int READ_LAT    = 2;
    localparam int BANK_SEL_HI = 2;
    localparam int BANK_SEL_LO = 1;
    localparam int BANK_W      = BANK_SEL_HI - BANK_SEL_LO + 1;

    function automatic int timer_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/banked_mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : banked_mem_if
//  Brief    : Request/response bus between cache memory port and responder.
//  Revision : 1.0  initial release
// ============================================================================
interface banked_mem_if
    import banked_mem_responder_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0]    addr;
    logic [DATA_W-1:0]    data_in;
    logic                 rd;
    logic                 wr;
    logic [DATA_W-1:0]    data_out;
    logic                 rd_valid;
    logic [NUM_BANKS-1:0] busy;
    logic                 stall;
    logic                 err;

    modport master (
        output addr, data_in, rd, wr,
        input  data_out, rd_valid, busy, stall, err
    );

    modport slave (
        input  addr, data_in, rd, wr,
        output data_out, rd_valid, busy, stall, err
    );
endinterface
`default_nettype wire

// File: rtl/banked_mem_responder_mem_bank_timer.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bank_timer
//  Brief    : Per-bank occupancy counter; loads on accept, counts down to 0.
//  Revision : 1.0  initial release
// ============================================================================
module mem_bank_timer
    import banked_mem_responder_pkg::*;
#(
    parameter int BANK_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic busy
);
    localparam int CNT_W = timer_width(BANK_CYCLES);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= CNT_W'(BANK_CYCLES);
        end else if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign busy = (r_count != '0);
endmodule
`default_nettype wire

// File: rtl/banked_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : banked_mem_responder
//  Brief    : Four-bank word-interleaved memory, 2-cycle reads, bank stall.
//             Optional macro MEM_ALIGN_CHECK_EN flags odd byte addresses.
//  Revision : 1.0  initial release
// ============================================================================
module banked_mem_responder
    import banked_mem_responder_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int BANK_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    banked_mem_if.slave  bus
);
    localparam int WORDS = 2 ** (ADDR_W - 1);

    logic [DATA_W-1:0]    r_mem [WORDS];
    logic [BANK_W-1:0]    w_bank;
    logic [ADDR_W-2:0]    w_word;
    logic [NUM_BANKS-1:0] w_busy;
    logic                 w_req;
    logic                 w_both;
    logic                 w_misalign;
    logic                 w_err_cond;
    logic                 w_accept;
    logic                 r_rd_pending;
    logic [ADDR_W-2:0]    r_rd_word;

    assign w_bank = bus.addr[BANK_SEL_HI:BANK_SEL_LO];
    assign w_word = bus.addr[ADDR_W-1:1];
    assign w_req  = bus.rd | bus.wr;
    assign w_both = bus.rd & bus.wr;

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = w_req & bus.addr[0];
`else
    logic w_unused_lsb;
    assign w_unused_lsb = bus.addr[0];
    assign w_misalign   = 1'b0;
`endif

    assign w_err_cond = w_both | w_misalign;
    assign w_accept   = (bus.rd ^ bus.wr) & ~w_misalign & ~w_busy[w_bank];
    // Illegal requests are reported through err, never through stall.
    assign bus.stall  = w_req & ~w_err_cond & w_busy[w_bank];
    assign bus.busy   = w_busy;

    generate
        for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
            mem_bank_timer #(
                .BANK_CYCLES (BANK_CYCLES)
            ) u_timer (
                .clk  (clk),
                .rst  (rst),
                .load (w_accept && (w_bank == BANK_W'(b))),
                .busy (w_busy[b])
            );
        end
    endgenerate

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (w_accept && bus.wr) begin
            r_mem[w_word] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_pending <= 1'b0;
            r_rd_word    <= '0;
            bus.rd_valid <= 1'b0;
            bus.data_out <= '0;
            bus.err      <= 1'b0;
        end else begin
            r_rd_pending <= w_accept & bus.rd;
            if (w_accept && bus.rd) begin
                r_rd_word <= w_word;
            end
            bus.rd_valid <= r_rd_pending;
            if (r_rd_pending) begin
                bus.data_out <= r_mem[r_rd_word];
            end
            bus.err <= w_err_cond;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_banked_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_banked_mem_responder
//  Brief    : Directed + random bench with a cycle-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_banked_mem_responder;
    import banked_mem_responder_pkg::*;

    localparam int BC = 4;

    typedef struct {
        int          due;
        logic [15:0] data;
    } rd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    banked_mem_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    banked_mem_responder #(
        .ADDR_W      (16),
        .DATA_W      (16),
        .BANK_CYCLES (BC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: word store, per-bank busy horizon, outstanding reads.
    logic [15:0] mem_m [int];
    int          busy_until [NUM_BANKS];
    rd_t         rdq [$];
    int          cur = 0;
    logic        prev_err = 1'b0;
    logic [15:0] last_data = 16'h0;
    logic        last_acc = 1'b0;
    int          last_tries = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NUM_BANKS; i++) busy_until[i] = -1;
        rdq.delete();
        prev_err  = 1'b0;
        last_data = 16'h0;
    endtask

    // One cycle: drive at posedge+1, check mid-cycle, advance model, next posedge+1.
    task automatic step(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
        int          b;
        int          wi;
        logic [3:0]  exp_busy;
        logic        exp_valid, both, mis, acc, exp_stall;
        bus.rd = r; bus.wr = w; bus.addr = a; bus.data_in = d;
        #3;
        for (int i = 0; i < NUM_BANKS; i++) exp_busy[i] = (cur <= busy_until[i]);
        exp_valid = (rdq.size() > 0) && (rdq[0].due == cur);
        if (exp_valid) begin
            last_data = rdq[0].data;
            void'(rdq.pop_front());
        end
        b    = int'(a[2:1]);
        wi   = int'(a[15:1]);
        both = r & w;
`ifdef MEM_ALIGN_CHECK_EN
        mis  = (r | w) & a[0];
`else
        mis  = 1'b0;
`endif
        exp_stall = (r | w) & ~both & ~mis & exp_busy[b];
        acc       = (r ^ w) & ~mis & ~exp_busy[b];
        chk("stall", {15'h0, bus.stall}, {15'h0, exp_stall});
        chk("busy", {12'h0, bus.busy}, {12'h0, exp_busy});
        chk("rd_valid", {15'h0, bus.rd_valid}, {15'h0, exp_valid});
        chk("err", {15'h0, bus.err}, {15'h0, prev_err});
        chk("data_out", bus.data_out, last_data);
        if (acc) begin
            busy_until[b] = cur + BC;
            if (w) mem_m[wi] = d;
            else   rdq.push_back('{cur + READ_LAT, mem_m[wi]});
        end
        prev_err = both | mis;
        last_acc = acc;
        @(posedge clk);
        #1;
        cur++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic present(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
        last_tries = 0;
        do begin
            step(r, w, a, d);
            last_tries++;
        end while (!last_acc && last_tries < 20);
        chk("accept_timeout", {15'h0, last_acc}, 16'h1);
    endtask

    task automatic do_reset();
        bus.rd = 1'b0; bus.wr = 1'b0;
        rst = 1'b0;
        #2;
        chk("rst_busy", {12'h0, bus.busy}, 16'h0);
        chk("rst_rd_valid", {15'h0, bus.rd_valid}, 16'h0);
        chk("rst_data_out", bus.data_out, 16'h0);
        chk("rst_err", {15'h0, bus.err}, 16'h0);
        chk("rst_stall", {15'h0, bus.stall}, 16'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_clear();
        cur += 2;
    endtask

    initial begin
        logic        r, w;
        logic [14:0] wd;
        logic [15:0] a;
        int          roll;
        bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.data_in = '0;
        model_clear();
        #1;
        do_reset();

        for (int i = 0; i < 64; i++) begin
            a = 16'(i * 2);
            present(1'b0, 1'b1, a, a ^ 16'h5A3C);
        end
        present(1'b0, 1'b1, 16'hFFFE, 16'hA5A5);

        // Write then read back through the 2-cycle pipe.
        idle(5);
        present(1'b0, 1'b1, 16'h0010, 16'hBEEF);
        idle(5);
        present(1'b1, 1'b0, 16'h0010, 16'h0);
        idle(2);
        chk("t1_data", bus.data_out, 16'hBEEF);

        // One read to each bank on consecutive cycles.
        idle(6);
        step(1'b1, 1'b0, 16'h0000, 16'h0); chk("t2_acc0", {15'h0, last_acc}, 16'h1);
        step(1'b1, 1'b0, 16'h0002, 16'h0); chk("t2_acc1", {15'h0, last_acc}, 16'h1);
        step(1'b1, 1'b0, 16'h0004, 16'h0); chk("t2_acc2", {15'h0, last_acc}, 16'h1);
        step(1'b1, 1'b0, 16'h0006, 16'h0); chk("t2_acc3", {15'h0, last_acc}, 16'h1);
        idle(6);

        // Same-bank conflict stalls for the whole busy window.
        step(1'b1, 1'b0, 16'h0008, 16'h0);
        present(1'b1, 1'b0, 16'h0000, 16'h0);
        chk("t3_stall_cycles", 16'(last_tries - 1), 16'(BC));
        idle(6);

        // rd&wr together is rejected and leaves memory untouched.
        step(1'b1, 1'b1, 16'h0010, 16'h1234);
        idle(6);
        present(1'b1, 1'b0, 16'h0010, 16'h0);
        idle(2);
        chk("t4_data", bus.data_out, 16'hBEEF);
`ifdef MEM_ALIGN_CHECK_EN
        step(1'b1, 1'b0, 16'h0003, 16'h0);
        idle(5);
`endif

        // Reset with a read in flight, then storage survives.
        idle(5);
        step(1'b1, 1'b0, 16'h0010, 16'h0);
        do_reset();
        idle(4);
        present(1'b1, 1'b0, 16'h0010, 16'h0);
        idle(2);
        chk("t5_data", bus.data_out, 16'hBEEF);
        present(1'b1, 1'b0, 16'hFFFE, 16'h0);
        idle(2);
        chk("top_word", bus.data_out, 16'hA5A5);

        for (int i = 0; i < 400; i++) begin
            roll = int'($urandom_range(0, 9));
            r  = (roll < 4) || (roll == 8);
            w  = ((roll >= 4) && (roll < 8)) || (roll == 8);
            wd = ($urandom_range(0, 15) == 0) ? 15'h7FFF : 15'($urandom_range(0, 63));
            a  = {wd, 1'($urandom_range(0, 1))};
            step(r, w, a, 16'($urandom));
        end
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
